// File: rtl/img_stream_checker.sv
// Image readout stream checker: header, pixels (optionally decimated), Fletcher-32
// checksum and padding are checked against a programmed pattern, with error statistics.
module img_stream_checker #(
   parameter int unsigned DataWidth       = 16,
   parameter int unsigned PixelBits       = 12,
   parameter int unsigned DimWidth        = 12,
   parameter int unsigned MaxHeaderWords  = 32,
   parameter int unsigned MaxPaddingWords = 1024,
   parameter int unsigned CountWidth      = 24,
   localparam int unsigned HdrW = $clog2(MaxHeaderWords + 1),
   localparam int unsigned PadW = $clog2(MaxPaddingWords + 1)
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  cmd_start,
   input  logic [HdrW-1:0]       cfg_headerWords,
   input  logic [DimWidth-1:0]   cfg_width,
   input  logic [DimWidth-1:0]   cfg_height,
   input  logic [PadW-1:0]       cfg_paddingWords,
   input  logic [PixelBits-1:0]  cfg_pixelInitial,
   input  logic [PixelBits-1:0]  cfg_pixelDelta,
   input  logic [3:0]            cfg_filterPeriod,
   input  logic [3:0]            cfg_filterKeep,
   input  logic                  in_ready,
   input  logic                  in_trigger,
   input  logic [DataWidth-1:0]  in_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CountWidth-1:0] err_count,
   output logic [CountWidth-1:0] first_err_idx,
   output logic [CountWidth-1:0] word_count
);

   localparam int unsigned CntW  = (HdrW > PadW) ? HdrW : PadW;
   localparam int unsigned DimW1 = DimWidth + 1;

   typedef enum logic [2:0] {StIdle, StHeader, StPixel, StCheck, StPad, StTail} state_e;

   // Fletcher accumulation modulo 65535
   function automatic logic [15:0] mod_add(input logic [15:0] x, input logic [15:0] y);
      logic [16:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 17'd65535) s = s - 17'd65535;
      return s[15:0];
   endfunction

   // Shift-add product truncated to pixel width; only applied to latched configuration
   function automatic logic [PixelBits-1:0] mul_trunc(input logic [PixelBits-1:0] a,
                                                     input logic [DimWidth-1:0] b);
      logic [PixelBits-1:0] acc;
      acc = '0;
      for (int k = 0; k < int'(DimWidth); k++) if (b[k]) acc = acc + (a << k);
      return acc;
   endfunction

   state_e                 state_q, state_d;
   logic [HdrW-1:0]        hdr_q;
   logic [PadW-1:0]        pad_q;
   logic [DimWidth-1:0]    w_q, h_q;
   logic [PixelBits-1:0]   delta_q, col_skip_q, row_step_q, row_skip;
   logic [3:0]             period_q, keep_q, kskip_q, kskip;
   logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [DimWidth-1:0]    col_q, col_d, row_q, row_d;
   logic [3:0]             cph_q, cph_d, rph_q, rph_d, ncph, nrph;
   logic [PixelBits-1:0]   exp_q, exp_d, base_q, base_d, nexp, nbase;
   logic [DimW1-1:0]       nc, nr;
   logic [15:0]            ck_a_q, ck_a_d, ck_b_q, ck_b_d, fl_a, fl_b;
   logic [CountWidth-1:0]  err_q, err_d, first_q, first_d, words_q, words_d, idx_q, idx_d;
   logic                   done_q, done_d, pass_q, pass_d;
   logic                   xfer, err_hit, finish, pix_empty;

   assign xfer      = in_ready & in_trigger;
   assign busy      = (state_q != StIdle) && (state_q != StTail);
   assign cnt_inc   = cnt_q + CntW'(1);
   assign kskip     = cfg_filterPeriod - cfg_filterKeep + 4'd1;
   assign row_skip  = mul_trunc(row_step_q, DimWidth'(kskip_q));
   assign pix_empty = (w_q == '0) || (h_q == '0);
   assign fl_a      = mod_add(ck_a_q, 16'(in_data));
   assign fl_b      = mod_add(ck_b_q, fl_a);

   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;
   assign word_count    = words_q;

   // Position and expected value of the next kept pixel after the current one
   always_comb begin
      if ({1'b0, cph_q} + 5'd1 < {1'b0, keep_q}) begin
         nc   = {1'b0, col_q} + DimW1'(1);
         ncph = cph_q + 4'd1;
         nexp = exp_q + delta_q;
      end else begin
         nc   = {1'b0, col_q} + DimW1'(period_q - cph_q);
         ncph = '0;
         nexp = exp_q + col_skip_q;
      end
      if ({1'b0, rph_q} + 5'd1 < {1'b0, keep_q}) begin
         nr    = {1'b0, row_q} + DimW1'(1);
         nrph  = rph_q + 4'd1;
         nbase = base_q + row_step_q;
      end else begin
         nr    = {1'b0, row_q} + DimW1'(period_q - rph_q);
         nrph  = '0;
         nbase = base_q + row_skip;
      end
   end

   // Next-state, checking and error accounting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      cph_d   = cph_q;
      rph_d   = rph_q;
      exp_d   = exp_q;
      base_d  = base_q;
      ck_a_d  = ck_a_q;
      ck_b_d  = ck_b_q;
      err_d   = err_q;
      first_d = first_q;
      words_d = words_q;
      idx_d   = idx_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_hit = 1'b0;
      finish  = 1'b0;
      if (cmd_start) begin
         if (cfg_headerWords != '0)                     state_d = StHeader;
         else if (cfg_width == '0 || cfg_height == '0) state_d = StCheck;
         else                                           state_d = StPixel;
         cnt_d   = '0;
         col_d   = '0;
         row_d   = '0;
         cph_d   = '0;
         rph_d   = '0;
         exp_d   = cfg_pixelInitial;
         base_d  = cfg_pixelInitial;
         ck_a_d  = '0;
         ck_b_d  = '0;
         err_d   = '0;
         first_d = '0;
         words_d = '0;
         idx_d   = '0;
      end else if (xfer) begin
         if (state_q != StIdle) idx_d = idx_q + CountWidth'(1);
         if (busy) words_d = words_q + CountWidth'(1);
         unique case (state_q)
            StIdle: ;
            StHeader: begin
               ck_a_d = fl_a;
               ck_b_d = fl_b;
               cnt_d  = cnt_inc;
               if (cnt_inc == CntW'(hdr_q)) begin
                  cnt_d   = '0;
                  state_d = pix_empty ? StCheck : StPixel;
               end
            end
            StPixel: begin
               ck_a_d  = fl_a;
               ck_b_d  = fl_b;
               err_hit = (in_data != DataWidth'(exp_q));
               if (nc >= {1'b0, w_q}) begin
                  col_d  = '0;
                  cph_d  = '0;
                  row_d  = nr[DimWidth-1:0];
                  rph_d  = nrph;
                  exp_d  = nbase;
                  base_d = nbase;
                  if (nr >= {1'b0, h_q}) begin
                     cnt_d   = '0;
                     state_d = StCheck;
                  end
               end else begin
                  col_d = nc[DimWidth-1:0];
                  cph_d = ncph;
                  exp_d = nexp;
               end
            end
            StCheck: begin
               if (cnt_q == '0) begin
                  err_hit = (in_data != DataWidth'(ck_a_q));
                  cnt_d   = cnt_inc;
               end else begin
                  err_hit = (in_data != DataWidth'(ck_b_q));
                  cnt_d   = '0;
                  if (pad_q == '0) begin
                     state_d = StTail;
                     finish  = 1'b1;
                  end else begin
                     state_d = StPad;
                  end
               end
            end
            StPad: begin
               cnt_d = cnt_inc;
               if (cnt_inc == CntW'(pad_q)) begin
                  state_d = StTail;
                  finish  = 1'b1;
               end
            end
            StTail: err_hit = 1'b1;
            default: ;
         endcase
         if (err_hit) begin
            if (err_q != '1) err_d = err_q + CountWidth'(1);
            if (err_q == '0) first_d = idx_q;
         end
         if (finish) begin
            done_d = ~done_q;
            pass_d = (err_d == '0);
         end
         if (err_hit && state_q == StTail) pass_d = 1'b0;
      end
   end

   // Configuration latched per check, with derived step constants
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         hdr_q      <= '0;
         pad_q      <= '0;
         w_q        <= '0;
         h_q        <= '0;
         delta_q    <= '0;
         period_q   <= '0;
         keep_q     <= '0;
         kskip_q    <= '0;
         col_skip_q <= '0;
         row_step_q <= '0;
      end else if (cmd_start) begin
         hdr_q      <= cfg_headerWords;
         pad_q      <= cfg_paddingWords;
         w_q        <= cfg_width;
         h_q        <= cfg_height;
         delta_q    <= cfg_pixelDelta;
         period_q   <= cfg_filterPeriod;
         keep_q     <= cfg_filterKeep;
         kskip_q    <= kskip;
         col_skip_q <= mul_trunc(cfg_pixelDelta, DimWidth'(kskip));
         row_step_q <= mul_trunc(cfg_pixelDelta, cfg_width);
      end
   end

   // Check state and statistics registers
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         cph_q   <= '0;
         rph_q   <= '0;
         exp_q   <= '0;
         base_q  <= '0;
         ck_a_q  <= '0;
         ck_b_q  <= '0;
         err_q   <= '0;
         first_q <= '0;
         words_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cph_q   <= cph_d;
         rph_q   <= rph_d;
         exp_q   <= exp_d;
         base_q  <= base_d;
         ck_a_q  <= ck_a_d;
         ck_b_q  <= ck_b_d;
         err_q   <= err_d;
         first_q <= first_d;
         words_q <= words_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

endmodule

// File: tb/tb_img_stream_checker.sv
// Directed bench for img_stream_checker: table of check configurations with
// hand-computed results, plus reset and restart sequences.
module tb_img_stream_checker;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        cmd_start = 1'b0;
   logic [5:0]  cfg_headerWords = '0;
   logic [11:0] cfg_width = '0;
   logic [11:0] cfg_height = '0;
   logic [10:0] cfg_paddingWords = '0;
   logic [11:0] cfg_pixelInitial = '0;
   logic [11:0] cfg_pixelDelta = '0;
   logic [3:0]  cfg_filterPeriod = 4'd1;
   logic [3:0]  cfg_filterKeep = 4'd1;
   logic        in_ready = 1'b0;
   logic        in_trigger = 1'b0;
   logic [15:0] in_data = '0;
   logic        busy, done, pass;
   logic [23:0] err_count, first_err_idx, word_count;

   int n_vec  = 0;
   int n_miss = 0;

   img_stream_checker dut (
      .clk(clk), .rst_(rst_), .cmd_start(cmd_start),
      .cfg_headerWords(cfg_headerWords), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_paddingWords(cfg_paddingWords), .cfg_pixelInitial(cfg_pixelInitial),
      .cfg_pixelDelta(cfg_pixelDelta), .cfg_filterPeriod(cfg_filterPeriod),
      .cfg_filterKeep(cfg_filterKeep), .in_ready(in_ready), .in_trigger(in_trigger),
      .in_data(in_data), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_idx(first_err_idx), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hdr, w, h, pad, init, delta, per, keep;
      bit gaps;
      int bad1, mask, bad2, extra;
      int e_err, e_first, e_words;
      bit e_pass;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One transfer, optionally preceded by idle cycles with only one handshake half high
   task automatic put(input logic [15:0] w, input bit gaps);
      if (gaps) begin
         int n;
         n = $urandom_range(0, 3);
         repeat (n) begin
            in_data = 16'($urandom);
            case ($urandom_range(0, 2))
               0:       begin in_ready = 1'b1; in_trigger = 1'b0; end
               1:       begin in_ready = 1'b0; in_trigger = 1'b1; end
               default: begin in_ready = 1'b0; in_trigger = 1'b0; end
            endcase
            @(posedge clk); #1;
         end
      end
      in_data = w; in_ready = 1'b1; in_trigger = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0; in_trigger = 1'b0;
   endtask

   task automatic start(input vec_t v);
      cfg_headerWords  = 6'(v.hdr);
      cfg_width        = 12'(v.w);
      cfg_height       = 12'(v.h);
      cfg_paddingWords = 11'(v.pad);
      cfg_pixelInitial = 12'(v.init);
      cfg_pixelDelta   = 12'(v.delta);
      cfg_filterPeriod = 4'(v.per);
      cfg_filterKeep   = 4'(v.keep);
      cmd_start = 1'b1;
      @(posedge clk); #1;
      cmd_start = 1'b0;
   endtask

   function automatic logic [15:0] corrupt(input vec_t v, input int idx, input logic [15:0] w);
      if (idx == v.bad1 || idx == v.bad2) return w ^ 16'(v.mask);
      return w;
   endfunction

   // Emit the stream for v, stopping after `limit` words (negative = whole stream)
   task automatic stream(input vec_t v, input int limit);
      int idx, a, b;
      logic [15:0] w;
      idx = 0; a = 0; b = 0;
      for (int k = 0; k < v.hdr; k++) begin
         if (idx == limit) return;
         w = corrupt(v, idx, 16'(32'hA000 + k * 32'h111));
         a = (a + int'(w)) % 65535; b = (b + a) % 65535;
         put(w, v.gaps); idx++;
      end
      for (int r = 0; r < v.h; r++) begin
         if (r % v.per >= v.keep) continue;
         for (int c = 0; c < v.w; c++) begin
            if (c % v.per >= v.keep) continue;
            if (idx == limit) return;
            w = corrupt(v, idx, 16'((v.init + (r * v.w + c) * v.delta) & 32'hFFF));
            a = (a + int'(w)) % 65535; b = (b + a) % 65535;
            put(w, v.gaps); idx++;
         end
      end
      if (idx == limit) return;
      put(corrupt(v, idx, 16'(a)), v.gaps); idx++;
      if (idx == limit) return;
      put(corrupt(v, idx, 16'(b)), v.gaps); idx++;
      for (int k = 0; k < v.pad; k++) begin
         if (idx == limit) return;
         put(16'(32'hFFFF - k), v.gaps); idx++;
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic d0;
      d0 = done;
      start(v);
      chk($sformatf("v%0d_busy_start", n), busy, 1);
      chk($sformatf("v%0d_words_start", n), word_count, 0);
      chk($sformatf("v%0d_err_start", n), err_count, 0);
      stream(v, -1);
      chk($sformatf("v%0d_done_latency", n), done, !d0);
      for (int k = 0; k < v.extra; k++) put(16'(32'h1234 + k), v.gaps);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_once", n), done, !d0);
      chk($sformatf("v%0d_busy_end", n), busy, 0);
      chk($sformatf("v%0d_pass", n), pass, v.e_pass);
      chk($sformatf("v%0d_err_count", n), err_count, v.e_err);
      chk($sformatf("v%0d_first_err", n), first_err_idx, v.e_first);
      chk($sformatf("v%0d_word_count", n), word_count, v.e_words);
   endtask

   initial begin
      //         hdr  w   h pad init    delta   per keep gaps bad1 mask     bad2 ext err first words pass
      vecs[0] = '{4,  8,  4, 3, 'hFFF, 'hFFF,  1,  1,  0,  -1,  0,       -1,  0,  0,  0,   41,  1};
      vecs[1] = '{4,  8,  4, 3, 'hFFF, 'hFFF,  1,  1,  1,  -1,  0,       -1,  0,  0,  0,   41,  1};
      vecs[2] = '{4, 16, 16, 3, 'hFFF, 'hFFF,  8,  2,  0,  -1,  0,       -1,  0,  0,  0,   25,  1};
      vecs[3] = '{4,  8,  4, 3, 'hFFF, 'hFFF,  1,  1,  0,  10,  1,       37,  0,  2, 10,   41,  0};
      vecs[4] = '{4,  8,  4, 3, 'hFFF, 'hFFF,  1,  1,  1,  -1,  0,       -1,  2,  2, 41,   41,  0};
      vecs[5] = '{3,  0,  4, 2, 'h123, 'h001,  1,  1,  0,  -1,  0,       -1,  0,  0,  0,    7,  1};
      vecs[6] = '{0,  4,  3, 0, 'h100, 'h007,  3,  2,  1,  -1,  0,       -1,  0,  0,  0,    8,  1};
      vecs[7] = '{1,  4,  2, 1, 'h000, 'h005,  1,  1,  0,   1,  'h8000,  -1,  0,  1,  1,   12,  0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_first", first_err_idx, 0);
      chk("rst_words", word_count, 0);
      rst_ = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Asynchronous reset in the middle of the pixel phase
      start(vecs[3]);
      stream(vecs[3], 11);
      chk("midrst_err_before", err_count, 1);
      chk("midrst_busy_before", busy, 1);
      @(negedge clk);
      rst_ = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err_count, 0);
      chk("midrst_first", first_err_idx, 0);
      chk("midrst_words", word_count, 0);
      @(posedge clk); #1;
      rst_ = 1'b1;
      @(posedge clk); #1;

      // Restart abandons a check with an error already recorded
      start(vecs[3]);
      stream(vecs[3], 11);
      chk("restart_err_before", err_count, 1);
      chk("restart_first_before", first_err_idx, 10);
      run_vec(99, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
